// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared MIPS opcode constants, NOP encoding, reset PC and rt-reader decode
package if_id_stage_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction
endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard check of ID instr (id_instr,id_valid) against ID/EX load (idex_memread,idex_rt) -> stall
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  output logic        stall
);
  logic unused_imm;
  assign unused_imm = ^id_instr[15:0];
  assign stall = id_valid & idex_memread & (idex_rt != 5'd0) &
                 ((idex_rt == id_instr[25:21]) | (reads_rt(id_instr[31:26]) & (idex_rt == id_instr[20:16])));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID register (if_pc4,if_instr,flush -> id_pc4,id_instr,id_valid), load-use stall (pc_wr,id_bubble), saturating stall/flush counters
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  output logic        pc_wr,
  output logic        id_bubble,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic stall;
  load_use_detect u_detect (
    .id_instr(id_instr),
    .id_valid(id_valid),
    .idex_memread(idex_memread),
    .idex_rt(idex_rt),
    .stall(stall)
  );
  assign pc_wr = ~stall;
  assign id_bubble = stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= INSTR_NOP;
      id_pc4 <= '0;
      id_valid <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!stall) begin
        id_instr <= flush ? INSTR_NOP : if_instr;
        id_pc4 <= flush ? 32'd0 : if_pc4;
        id_valid <= ~flush;
      end
      stall_cnt <= stall_cnt + {15'd0, stall & ~&stall_cnt};
      flush_cnt <= flush_cnt + {15'd0, flush & ~stall & ~&flush_cnt};
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage
module tb_if_id_stage;
  logic        clk, rst, flush, idex_memread;
  logic [31:0] if_pc4, if_instr;
  logic [4:0]  idex_rt;
  logic        pc_wr, id_bubble, id_valid;
  logic [31:0] id_pc4, id_instr;
  logic [15:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;

  if_id_stage dut (
    .clk(clk), .rst(rst), .if_pc4(if_pc4), .if_instr(if_instr), .flush(flush),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .pc_wr(pc_wr), .id_bubble(id_bubble),
    .id_pc4(id_pc4), .id_instr(id_instr), .id_valid(id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    if_pc4 = 32'h0; if_instr = 32'h0;
    #1 rst = 1'b1;
    #2;
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_pc_wr", {31'd0, pc_wr}, 32'd1);
    check("rst_bubble", {31'd0, id_bubble}, 32'd0);
    check("rst_scnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_fcnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_instr = 32'h2008_0005; if_pc4 = 32'h3004;
    tick();
    check("plain_instr", id_instr, 32'h2008_0005);
    check("plain_pc4", id_pc4, 32'h3004);
    check("plain_valid", {31'd0, id_valid}, 32'd1);
    check("plain_pc_wr", {31'd0, pc_wr}, 32'd1);
    if_instr = 32'h0109_1820; if_pc4 = 32'h3008;
    tick();
    check("add_loaded", id_instr, 32'h0109_1820);
    idex_memread = 1'b1; idex_rt = 5'd8;
    if_instr = 32'h3c01_0000; if_pc4 = 32'h300c;
    #1;
    check("lu_rs_pc_wr", {31'd0, pc_wr}, 32'd0);
    check("lu_rs_bubble", {31'd0, id_bubble}, 32'd1);
    tick();
    check("lu_hold_instr", id_instr, 32'h0109_1820);
    check("lu_hold_pc4", id_pc4, 32'h3008);
    check("lu_scnt1", {16'd0, stall_cnt}, 32'd1);
    idex_memread = 1'b0;
    #1 check("lu_clear_pc_wr", {31'd0, pc_wr}, 32'd1);
    idex_memread = 1'b1; idex_rt = 5'd9;
    #1 check("rt_add_stall", {31'd0, pc_wr}, 32'd0);
    idex_rt = 5'd0;
    #1 check("rt0_no_stall", {31'd0, pc_wr}, 32'd1);
    idex_rt = 5'd9; flush = 1'b1;
    tick();
    check("fl_stall_instr", id_instr, 32'h0109_1820);
    check("fl_stall_valid", {31'd0, id_valid}, 32'd1);
    check("fl_stall_fcnt", {16'd0, flush_cnt}, 32'd0);
    check("fl_stall_scnt", {16'd0, stall_cnt}, 32'd2);
    idex_memread = 1'b0; flush = 1'b0;
    if_instr = 32'h2109_0001; if_pc4 = 32'h3010;
    tick();
    check("addi_loaded", id_instr, 32'h2109_0001);
    idex_memread = 1'b1; idex_rt = 5'd9;
    #1 check("addi_rt_no_stall", {31'd0, pc_wr}, 32'd1);
    idex_rt = 5'd8;
    #1 check("addi_rs_stall", {31'd0, pc_wr}, 32'd0);
    idex_memread = 1'b0; flush = 1'b1;
    tick();
    check("flush_instr", id_instr, 32'h0);
    check("flush_valid", {31'd0, id_valid}, 32'd0);
    check("flush_pc4", id_pc4, 32'h0);
    check("flush_fcnt1", {16'd0, flush_cnt}, 32'd1);
    tick();
    check("flush2_instr", id_instr, 32'h0);
    check("flush2_fcnt", {16'd0, flush_cnt}, 32'd2);
    flush = 1'b0; if_instr = 32'h0; if_pc4 = 32'h3014;
    tick();
    check("nop_valid", {31'd0, id_valid}, 32'd1);
    idex_memread = 1'b1; idex_rt = 5'd0;
    #1 check("zero_reg_guard", {31'd0, pc_wr}, 32'd1);
    idex_memread = 1'b0; if_instr = 32'h0109_1820; if_pc4 = 32'h3018;
    tick();
    idex_memread = 1'b1; idex_rt = 5'd8;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("sat_scnt", {16'd0, stall_cnt}, 32'h0000_ffff);
    check("sat_hold_instr", id_instr, 32'h0109_1820);
    check("sat_fcnt", {16'd0, flush_cnt}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_instr", id_instr, 32'h0);
    check("arst_pc4", id_pc4, 32'h0);
    check("arst_valid", {31'd0, id_valid}, 32'd0);
    check("arst_scnt", {16'd0, stall_cnt}, 32'd0);
    check("arst_fcnt", {16'd0, flush_cnt}, 32'd0);
    check("arst_pc_wr", {31'd0, pc_wr}, 32'd1);
    check("arst_bubble", {31'd0, id_bubble}, 32'd0);
    @(negedge clk);
    rst = 1'b0; idex_memread = 1'b0;
    if_instr = 32'h8c08_0004; if_pc4 = 32'h3004;
    tick();
    check("post_rst_instr", id_instr, 32'h8c08_0004);
    check("post_rst_pc4", id_pc4, 32'h3004);
    check("post_rst_valid", {31'd0, id_valid}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
